// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt controller: register map,
// ICR bit positions and the source-vector type.
package irq_pkg;

    localparam logic [7:0] ADDR_IER = 8'h00;
    localparam logic [7:0] ADDR_IPR = 8'h01;
    localparam logic [7:0] ADDR_ICR = 8'h02;
    localparam logic [7:0] ADDR_IVR = 8'h03;

    localparam int ICR_GEN_BIT = 0;
    localparam int ICR_SWI_BIT = 1;
    localparam int MAX_SRC     = 8;

    typedef logic [7:0] irq_vec_t;

    // Bits below n set; used to tie unimplemented source bits to zero.
    function automatic irq_vec_t src_mask(input int n);
        irq_vec_t m;
        m = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; id is 0 when nothing is set.
module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         any,
    output logic [2:0]   id
);

    always_comb begin
        any = |req;
        id  = '0;
        // Scan downward so the lowest active index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) id = 3'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-captures source flags into pending bits, masks them,
// and presents one registered IRQ line plus vector; programmed over an APB-style bus.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic              irq_ack,
    output logic              irq_o,
    output logic [2:0]        irq_id
);

    localparam irq_vec_t SRC_MASK = src_mask(NUM_SRC);

    logic [NUM_SRC-1:0] src_q;
    irq_vec_t ier, ipr, ipr_nxt, set_v, clr_v, rise_v, act, wdata, rd_data;
    logic     gen;
    logic     setup_ph, wr_acc;
    logic     sel_ier, sel_ipr, sel_icr, sel_ivr, mapped;
    logic     any_act;
    logic [2:0] id_nxt;

    assign pready   = 1'b1;
    assign setup_ph = psel & ~penable;
    assign wr_acc   = psel & penable & pwrite;
    assign wdata    = irq_vec_t'(pwdata);

    assign sel_ier = (paddr == ADDR_W'(ADDR_IER));
    assign sel_ipr = (paddr == ADDR_W'(ADDR_IPR));
    assign sel_icr = (paddr == ADDR_W'(ADDR_ICR));
    assign sel_ivr = (paddr == ADDR_W'(ADDR_IVR));
    assign mapped  = sel_ier | sel_ipr | sel_icr | sel_ivr;

    assign rise_v = irq_vec_t'(src_i & ~src_q);
    assign act    = ipr & ier;

    irq_prio_enc #(.N(NUM_SRC)) u_prio (
        .req (act[NUM_SRC-1:0]),
        .any (any_act),
        .id  (id_nxt)
    );

    // Set sources are applied after clears so a same-cycle set always wins.
    always_comb begin
        set_v = rise_v;
        clr_v = '0;
        if (wr_acc && sel_ipr) clr_v = wdata;
        if (wr_acc && sel_icr && wdata[ICR_SWI_BIT]) set_v[0] = 1'b1;
        if (irq_ack && irq_o) clr_v[irq_id] = 1'b1;
        ipr_nxt = (set_v | (ipr & ~clr_v)) & SRC_MASK;
    end

    always_comb begin
        rd_data = '0;
        if (sel_ier) rd_data = ier;
        if (sel_ipr) rd_data = ipr;
        if (sel_icr) rd_data = irq_vec_t'(gen);
        if (sel_ivr) rd_data = {irq_o, 4'b0000, irq_id};
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            src_q   <= '0;
            ier     <= '0;
            ipr     <= '0;
            gen     <= 1'b0;
            irq_o   <= 1'b0;
            irq_id  <= '0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            src_q  <= src_i;
            ipr    <= ipr_nxt;
            if (wr_acc && sel_ier) ier <= wdata & SRC_MASK;
            if (wr_acc && sel_icr) gen <= wdata[ICR_GEN_BIT];
            irq_o  <= gen & any_act;
            irq_id <= id_nxt;
            // Read data and error are captured in setup and held through the access phase.
            if (setup_ph) begin
                prdata  <= pwrite ? '0 : DATA_W'(rd_data);
                pslverr <= ~mapped;
            end else begin
                prdata  <= '0;
                pslverr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomized bench for irq_ctrl against a cycle-level reference model.
module tb_irq_ctrl;

    logic       pclk;
    logic       preset;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready, pslverr;
    logic [7:0] src;
    logic       irq_ack;
    logic       irq_o;
    logic [2:0] irq_id;

    int tests  = 0;
    int failed = 0;

    // reference model state
    logic [7:0] m_ier, m_ipr, m_srcq, m_prdata;
    logic       m_gen, m_irq, m_err;
    logic [2:0] m_id;

    irq_ctrl #(.NUM_SRC(8), .ADDR_W(8), .DATA_W(8)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .src_i   (src),
        .irq_ack (irq_ack),
        .irq_o   (irq_o),
        .irq_id  (irq_id)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] lowest(input logic [7:0] a);
        logic [7:0] lb;
        lb = a & (~a + 8'd1);
        if (lb == 8'd0) return 3'd0;
        return 3'($clog2(lb));
    endfunction

    // Advance one clock: predict from the rules, step the clock, compare outputs.
    task automatic tick();
        logic [7:0] setv, clrv, act, n_ier, n_ipr, n_pr, rv;
        logic       n_gen, n_err, n_irq;
        logic [2:0] n_id;
        setv  = src & ~m_srcq;
        clrv  = 8'h00;
        n_ier = m_ier;
        n_gen = m_gen;
        act   = m_ipr & m_ier;
        if (psel && penable && pwrite) begin
            case (paddr)
                8'h00: n_ier = pwdata;
                8'h01: clrv = pwdata;
                8'h02: begin
                    n_gen = pwdata[0];
                    if (pwdata[1]) setv[0] = 1'b1;
                end
                default: ;
            endcase
        end
        if (irq_ack && m_irq) clrv[m_id] = 1'b1;
        n_ipr = setv | (m_ipr & ~clrv);
        case (paddr)
            8'h00:   rv = m_ier;
            8'h01:   rv = m_ipr;
            8'h02:   rv = {7'b0, m_gen};
            8'h03:   rv = {m_irq, 4'b0, m_id};
            default: rv = 8'h00;
        endcase
        n_pr  = 8'h00;
        n_err = 1'b0;
        if (psel && !penable) begin
            n_pr  = pwrite ? 8'h00 : rv;
            n_err = (paddr > 8'h03);
        end
        n_irq = m_gen && (act != 8'h00);
        n_id  = lowest(act);

        @(posedge pclk);
        #1;
        if (preset) begin
            m_ier = 0; m_ipr = 0; m_srcq = 0; m_gen = 0;
            m_irq = 0; m_id = 0; m_prdata = 0; m_err = 0;
        end else begin
            m_ier = n_ier; m_ipr = n_ipr; m_srcq = src; m_gen = n_gen;
            m_irq = n_irq; m_id = n_id; m_prdata = n_pr; m_err = n_err;
        end
        chk("irq_o",   {7'b0, irq_o},   {7'b0, m_irq});
        chk("irq_id",  {5'b0, irq_id},  {5'b0, m_id});
        chk("prdata",  prdata,          m_prdata);
        chk("pslverr", {7'b0, pslverr}, {7'b0, m_err});
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [7:0] d, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        tick();
        penable = 1'b1;
        d = prdata;
        e = pslverr;
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;
        int         op;

        m_ier = 0; m_ipr = 0; m_srcq = 0; m_gen = 0;
        m_irq = 0; m_id = 0; m_prdata = 0; m_err = 0;
        preset = 1'b1; psel = 0; penable = 0; pwrite = 0;
        paddr = 0; pwdata = 0; src = 0; irq_ack = 0;

        // reset
        tick();
        tick();
        preset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            apb_read(8'(a), rd, er);
            chk("reset_read", rd, 8'h00);
            chk("reset_err", {7'b0, er}, 8'h00);
        end
        chk("reset_irq", {7'b0, irq_o}, 8'h00);

        // mid-transfer reset aborts the write
        psel = 1; pwrite = 1; paddr = 8'h00; pwdata = 8'hFF; penable = 0;
        tick();
        penable = 1; preset = 1;
        tick();
        preset = 0; psel = 0; penable = 0; pwrite = 0;
        apb_read(8'h00, rd, er);
        chk("abort_ier", rd, 8'h00);

        // timer overflow path
        apb_write(8'h00, 8'h01);
        apb_write(8'h02, 8'h01);
        src = 8'h01;
        tick();
        src = 8'h00;
        chk("ovf_lat1", {7'b0, irq_o}, 8'h00);
        tick();
        chk("ovf_lat2", {7'b0, irq_o}, 8'h01);
        apb_read(8'h03, rd, er);
        chk("ovf_ivr", rd, 8'h80);
        apb_write(8'h01, 8'h01);
        tick();
        chk("ovf_clr_irq", {7'b0, irq_o}, 8'h00);
        apb_read(8'h01, rd, er);
        chk("ovf_ipr", rd, 8'h00);

        // priority and acknowledge
        apb_write(8'h00, 8'h0F);
        src = 8'h0A;
        tick();
        src = 8'h00;
        tick();
        chk("prio_id1", {5'b0, irq_id}, 8'h01);
        irq_ack = 1;
        tick();
        irq_ack = 0;
        tick();
        chk("prio_id3", {5'b0, irq_id}, 8'h03);
        apb_read(8'h01, rd, er);
        chk("prio_ipr8", rd, 8'h08);
        irq_ack = 1;
        tick();
        irq_ack = 0;
        tick();
        chk("prio_done", {7'b0, irq_o}, 8'h00);
        apb_read(8'h01, rd, er);
        chk("prio_ipr0", rd, 8'h00);

        // masking keeps pending
        apb_write(8'h00, 8'h00);
        src = 8'h04;
        tick();
        src = 8'h00;
        tick();
        tick();
        chk("mask_irq0", {7'b0, irq_o}, 8'h00);
        apb_read(8'h01, rd, er);
        chk("mask_ipr", rd, 8'h04);
        apb_write(8'h00, 8'h04);
        tick();
        chk("mask_irq1", {7'b0, irq_o}, 8'h01);
        apb_write(8'h01, 8'h04);

        // set beats clear; held level does not re-set
        src = 8'h01;
        tick();
        src = 8'h00;
        tick();
        psel = 1; pwrite = 1; paddr = 8'h01; pwdata = 8'h01; penable = 0;
        tick();
        penable = 1; src = 8'h01;
        tick();
        psel = 0; penable = 0; pwrite = 0;
        apb_read(8'h01, rd, er);
        chk("coll_ipr", rd, 8'h01);
        apb_write(8'h01, 8'h01);
        tick();
        tick();
        apb_read(8'h01, rd, er);
        chk("held_ipr", rd, 8'h00);
        src = 8'h00;

        // bus errors and read-only IVR
        apb_read(8'h10, rd, er);
        chk("err_rd", rd, 8'h00);
        chk("err_rd_flag", {7'b0, er}, 8'h01);
        apb_write(8'h10, 8'hFF);
        apb_read(8'h00, rd, er);
        chk("err_ier", rd, 8'h04);
        apb_write(8'h03, 8'hFF);
        apb_read(8'h03, rd, er);
        chk("ivr_ro", rd, 8'h00);
        chk("ivr_err", {7'b0, er}, 8'h00);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            src = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            op  = int'($urandom_range(0, 5));
            if (op == 0) begin
                apb_write(8'($urandom_range(0, 4)) == 8'h04 ? 8'h10 : 8'($urandom_range(0, 3)),
                          8'($urandom));
            end else if (op == 1) begin
                apb_read((8'($urandom_range(0, 4)) == 8'h04) ? 8'h10 : 8'($urandom_range(0, 3)), rd, er);
            end else begin
                irq_ack = ($urandom_range(0, 3) == 0);
                tick();
                irq_ack = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
